// File: rtl/hx711_bin2bcd_pkg.sv
// rtl/hx711_bin2bcd_pkg.sv - shared constants and FSM encoding for the HX711 binary-to-BCD converter
package hx711_pkg;

  localparam int DATA_W  = 24;
  localparam int DIGITS  = 6;
  localparam int BCD_MAX = 999999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CONVERT,
    S_DONE
  } state_t;

  // Largest value representable in the given number of BCD digits (10^digits - 1).
  function automatic longint bcd_max_of(input int digits);
    longint r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/hx711_bin2bcd_add3_shift.sv
// rtl/hx711_bin2bcd_add3_shift.sv - one shift-add-3 iteration over a packed BCD accumulator
module bcd_add3_shift #(
  parameter int DIGITS = hx711_pkg::DIGITS
) (
  input  logic [4*DIGITS-1:0] acc,
  input  logic                bit_in,
  output logic [4*DIGITS-1:0] acc_next
);

  localparam int BCD_W = 4 * DIGITS;

  logic [BCD_W-1:0] adj;

  // Pre-correct every digit that would reach 10+ after doubling, then shift the next binary bit in.
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    acc_next = (adj << 1) | BCD_W'(bit_in);
  end

endmodule

// File: rtl/hx711_bin2bcd.sv
// rtl/hx711_bin2bcd.sv - sequential signed 24-bit sample to 6-digit BCD converter with sign and overflow
module hx711_bin2bcd #(
  parameter int DATA_W = hx711_pkg::DATA_W,
  parameter int DIGITS = hx711_pkg::DIGITS,
  parameter int SHIFT  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                data_valid,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                neg,
  output logic                overflow,
  output logic                busy,
  output logic                bcd_valid
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = $clog2(DATA_W + 1);
  localparam logic [63:0] LIMIT64 = 64'(hx711_pkg::bcd_max_of(DIGITS));

  hx711_pkg::state_t state, state_next;

  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] mag_s;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-1:0]  acc_next;
  logic [CNT_W-1:0]  cnt;
  logic              neg_pend;
  logic              ovf_pend;
  logic              too_big;
  logic              last_iter;

  // Magnitude of the captured sample; unsigned negate so the most negative code does not wrap.
  always_comb begin
    mag       = sample[DATA_W-1] ? (~sample + 1'b1) : sample;
    mag_s     = mag >> SHIFT;
    too_big   = (64'(mag_s) > LIMIT64);
    last_iter = (cnt == CNT_W'(DATA_W - 1));
  end

  bcd_add3_shift #(
    .DIGITS (DIGITS)
  ) u_add3_shift (
    .acc      (acc),
    .bit_in   (operand[DATA_W-1]),
    .acc_next (acc_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= hx711_pkg::S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; every non-idle state counts as busy so late samples are dropped.
  always_comb begin
    state_next = state;
    busy       = (state != hx711_pkg::S_IDLE);
    case (state)
      hx711_pkg::S_IDLE:    if (data_valid) state_next = hx711_pkg::S_LOAD;
      hx711_pkg::S_LOAD:    state_next = hx711_pkg::S_CONVERT;
      hx711_pkg::S_CONVERT: if (last_iter) state_next = hx711_pkg::S_DONE;
      hx711_pkg::S_DONE:    state_next = hx711_pkg::S_IDLE;
      default:              state_next = hx711_pkg::S_IDLE;
    endcase
  end

  // Datapath: capture, clip/load, iterate, then publish results together with the valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample    <= '0;
      operand   <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_pend  <= 1'b0;
      ovf_pend  <= 1'b0;
      bcd_out   <= '0;
      neg       <= 1'b0;
      overflow  <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        hx711_pkg::S_IDLE: begin
          if (data_valid) sample <= data_in;
        end
        hx711_pkg::S_LOAD: begin
          neg_pend <= sample[DATA_W-1] && (mag_s != '0);
          ovf_pend <= too_big;
          operand  <= too_big ? DATA_W'(LIMIT64) : mag_s;
          acc      <= '0;
          cnt      <= '0;
        end
        hx711_pkg::S_CONVERT: begin
          acc     <= acc_next;
          operand <= operand << 1;
          cnt     <= cnt + 1'b1;
        end
        hx711_pkg::S_DONE: begin
          bcd_out   <= acc;
          neg       <= neg_pend;
          overflow  <= ovf_pend;
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hx711_bin2bcd.sv
// tb/tb_hx711_bin2bcd.sv - scoreboard bench for hx711_bin2bcd at SHIFT=0 and SHIFT=4
module tb_hx711_bin2bcd;

  localparam int LAT = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] din0, din4;
  logic        dv0, dv4;
  logic [23:0] bcd0, bcd4;
  logic        neg0, neg4, ovf0, ovf4, busy0, busy4, bv0, bv4;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int vcnt0 = 0;
  int vcnt4 = 0;

  typedef struct {
    logic [23:0] bcd;
    logic        neg;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  hx711_bin2bcd #(.DATA_W(24), .DIGITS(6), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .data_in(din0), .data_valid(dv0),
    .bcd_out(bcd0), .neg(neg0), .overflow(ovf0), .busy(busy0), .bcd_valid(bv0)
  );

  hx711_bin2bcd #(.DATA_W(24), .DIGITS(6), .SHIFT(4)) dut_s4 (
    .clk(clk), .rst(rst), .data_in(din4), .data_valid(dv4),
    .bcd_out(bcd4), .neg(neg4), .overflow(ovf4), .busy(busy4), .bcd_valid(bv4)
  );

  function automatic exp_t model(input logic [23:0] d, input int sh, input int due);
    exp_t        e;
    logic [23:0] mag, ms;
    int          v;
    mag   = d[23] ? (24'd0 - d) : d;
    ms    = mag >> sh;
    e.ovf = (ms > 24'd999999);
    v     = e.ovf ? 999999 : int'(ms);
    e.bcd = '0;
    for (int i = 0; i < 6; i++) begin
      e.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    e.neg = d[23] && (ms != 0);
    e.due = due;
    return e;
  endfunction

  // Scoreboard for the SHIFT=0 instance
  always @(negedge clk) begin
    exp_t e;
    if (bv0) begin
      vcnt0++;
      n_vec++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid0 cyc=%0d bcd=%h neg=%b ovf=%b", cyc, bcd0, neg0, ovf0);
      end else begin
        e = q0.pop_front();
        if ({bcd0, neg0, ovf0} !== {e.bcd, e.neg, e.ovf} || cyc != e.due) begin
          n_bad++;
          $display("FAIL result0 got bcd=%h neg=%b ovf=%b cyc=%0d exp bcd=%h neg=%b ovf=%b cyc=%0d",
                   bcd0, neg0, ovf0, cyc, e.bcd, e.neg, e.ovf, e.due);
        end
      end
    end else if (q0.size() > 0 && cyc > q0[0].due) begin
      n_vec++;
      n_bad++;
      $display("FAIL late0 no bcd_valid by cyc=%0d exp cyc=%0d", cyc, q0[0].due);
      void'(q0.pop_front());
    end
  end

  // Scoreboard for the SHIFT=4 instance
  always @(negedge clk) begin
    exp_t e;
    if (bv4) begin
      vcnt4++;
      n_vec++;
      if (q4.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid4 cyc=%0d bcd=%h neg=%b ovf=%b", cyc, bcd4, neg4, ovf4);
      end else begin
        e = q4.pop_front();
        if ({bcd4, neg4, ovf4} !== {e.bcd, e.neg, e.ovf} || cyc != e.due) begin
          n_bad++;
          $display("FAIL result4 got bcd=%h neg=%b ovf=%b cyc=%0d exp bcd=%h neg=%b ovf=%b cyc=%0d",
                   bcd4, neg4, ovf4, cyc, e.bcd, e.neg, e.ovf, e.due);
        end
      end
    end else if (q4.size() > 0 && cyc > q4[0].due) begin
      n_vec++;
      n_bad++;
      $display("FAIL late4 no bcd_valid by cyc=%0d exp cyc=%0d", cyc, q4[0].due);
      void'(q4.pop_front());
    end
  end

  task automatic send0(input logic [23:0] d, input bit expect_it);
    @(negedge clk);
    din0 = d;
    dv0  = 1'b1;
    if (expect_it) q0.push_back(model(d, 0, cyc + 1 + LAT));
    @(negedge clk);
    dv0 = 1'b0;
  endtask

  task automatic send4(input logic [23:0] d);
    @(negedge clk);
    din4 = d;
    dv4  = 1'b1;
    q4.push_back(model(d, 4, cyc + 1 + LAT));
    @(negedge clk);
    dv4 = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q4.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (q0.size() != 0 || q4.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout pending0=%0d pending4=%0d required 0", q0.size(), q4.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dv0 = 1'b0; dv4 = 1'b0; din0 = '0; din4 = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bcd0, neg0, ovf0, busy0, bv0} !== 28'd0) begin
      n_bad++;
      $display("FAIL reset0 got %h required 0", {bcd0, neg0, ovf0, busy0, bv0});
    end
    n_vec++;
    if ({bcd4, neg4, ovf4, busy4, bv4} !== 28'd0) begin
      n_bad++;
      $display("FAIL reset4 got %h required 0", {bcd4, neg4, ovf4, busy4, bv4});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_latency();
    int bad;
    bad = 0;
    send0(24'h000000, 1'b1);
    for (int j = 0; j < LAT; j++) begin
      if (busy0 !== 1'b1) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL busy_high got %0d low cycles required 0", bad);
    end
    n_vec++;
    if (busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_low got %b required 0", busy0);
    end
    drain();
  endtask

  task automatic test_values();
    send0(24'h01E240, 1'b1);
    drain();
    send0(24'hFFFFFF, 1'b1);
    drain();
    repeat (5) @(negedge clk);
    n_vec++;
    if ({bcd0, neg0} !== {24'h000001, 1'b1}) begin
      n_bad++;
      $display("FAIL hold got bcd=%h neg=%b required bcd=000001 neg=1", bcd0, neg0);
    end
  endtask

  task automatic test_overflow();
    send0(24'h0F423F, 1'b1);
    drain();
    send0(24'h0F4240, 1'b1);
    drain();
    send0(24'h800000, 1'b1);
    drain();
  endtask

  task automatic test_shift();
    send4(24'h7FFFFF);
    drain();
    send4(24'hFFFFFF);
    drain();
    send4(24'hFFFFF0);
    drain();
  endtask

  task automatic test_back_to_back();
    int v;
    v = vcnt0;
    send0(24'h09FBF1, 1'b1);
    repeat (4) @(negedge clk);
    din0 = 24'h000777;
    dv0  = 1'b1;
    @(negedge clk);
    dv0 = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    n_vec++;
    if (vcnt0 - v != 1) begin
      n_bad++;
      $display("FAIL back_to_back_pulses got %0d required 1", vcnt0 - v);
    end
  endtask

  task automatic test_reset_abort();
    int v;
    send0(24'h01E240, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({bcd0, neg0, ovf0, busy0, bv0} !== 28'd0) begin
      n_bad++;
      $display("FAIL abort_clear got %h required 0", {bcd0, neg0, ovf0, busy0, bv0});
    end
    v = vcnt0;
    repeat (30) @(negedge clk);
    n_vec++;
    if (vcnt0 != v) begin
      n_bad++;
      $display("FAIL abort_no_valid got %0d pulses required 0", vcnt0 - v);
    end
    send0(24'd42, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_values();
    test_overflow();
    test_shift();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
